// File: rtl/temp_pkg.sv
// Shared types and helpers for the temperature polling path.
// The sign-magnitude conversion lives here so the display logic can reuse it.
package temp_pkg;

  localparam int TEMP_W       = 13;
  localparam int MAG_W        = 12;
  localparam int LSB_PER_DEGC = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE
  } pollState_t;

  // Sign-magnitude to two's complement; a negative zero comes out as 0.
  function automatic logic signed [TEMP_W-1:0] sm_to_tc(input logic sign,
                                                        input logic [MAG_W-1:0] mag);
    logic signed [TEMP_W-1:0] ext;
    ext = {1'b0, mag};
    return sign ? -ext : ext;
  endfunction

endpackage

// File: rtl/temp_poller_if.sv
// Link between the poller and the mcp9808 interface block.
// The poller requests with update; the sensor side reports busy/idle and data.
interface temp_poller_if;
  import temp_pkg::*;

  logic             update;
  logic             ready;
  logic [MAG_W-1:0] temp_val;
  logic             temp_sign;

  modport master (output update, input ready, input temp_val, input temp_sign);
  modport slave  (input update, output ready, output temp_val, output temp_sign);

endinterface

// File: rtl/temp_minmax_alarm.sv
// Min/max tracker and hysteretic over-temperature alarm.
// Everything here only changes on the capture strobe from the poller FSM,
// except that a clear request can mark the extremes empty at any time.
module temp_minmax_alarm
  import temp_pkg::*;
#(
  parameter int HYST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     captureEn,
  input  logic                     clearMinmax,
  input  logic signed [TEMP_W-1:0] sampleIn,
  input  logic signed [TEMP_W-1:0] alarmThresh,
  output logic signed [TEMP_W-1:0] tMin,
  output logic signed [TEMP_W-1:0] tMax,
  output logic                     alarm
);

  localparam int WIDE_W = TEMP_W + 1;

  logic                     empty;
  logic signed [WIDE_W-1:0] sampleWide;
  logic signed [WIDE_W-1:0] lowBound;
  logic                     alarmSet;
  logic                     alarmClr;

  // The clear bound is one bit wider so thresholds near the negative limit do not wrap.
  assign sampleWide = {sampleIn[TEMP_W-1], sampleIn};
  assign lowBound   = {alarmThresh[TEMP_W-1], alarmThresh} - WIDE_W'(HYST);
  assign alarmSet   = (sampleIn >= alarmThresh);
  assign alarmClr   = (sampleWide < lowBound);

  // Extremes reload on the first capture after reset or clear, then track by signed compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      tMin  <= '0;
      tMax  <= '0;
      empty <= 1'b1;
      alarm <= 1'b0;
    end else if (captureEn) begin
      if (empty || clearMinmax) begin
        tMin  <= sampleIn;
        tMax  <= sampleIn;
        empty <= 1'b0;
      end else begin
        if (sampleIn < tMin) tMin <= sampleIn;
        if (sampleIn > tMax) tMax <= sampleIn;
      end
      if (alarmSet) begin
        alarm <= 1'b1;
      end else if (alarmClr) begin
        alarm <= 1'b0;
      end
    end else if (clearMinmax) begin
      empty <= 1'b1;
    end
  end

endmodule

// File: rtl/temp_poller.sv
// Autonomous poller for the mcp9808 interface block.
// Periodically requests a conversion, waits for the busy/idle handshake,
// captures the reading as two's complement and watches for hung transactions.
module temp_poller
  import temp_pkg::*;
#(
  parameter int PERIOD  = 100_000_000,
  parameter int TIMEOUT = 1_000_000,
  parameter int HYST    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  temp_poller_if.master            mcp,
  input  logic                     clear_minmax,
  input  logic signed [TEMP_W-1:0] alarm_thresh,
  output logic signed [TEMP_W-1:0] sample,
  output logic                     sample_valid,
  output logic signed [TEMP_W-1:0] t_min,
  output logic signed [TEMP_W-1:0] t_max,
  output logic                     alarm,
  output logic                     timeout_err
);

  localparam int TIMER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  pollState_t               state;
  pollState_t               nextState;
  logic [TIMER_W-1:0]       timer;
  logic [WAIT_W-1:0]        waitCnt;
  logic                     timerDone;
  logic                     inWait;
  logic                     timeoutHit;
  logic                     captureEn;
  logic                     updateReg;
  logic signed [TEMP_W-1:0] converted;

  assign timerDone  = (timer == TIMER_W'(PERIOD - 1));
  assign inWait     = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timeoutHit = inWait && (waitCnt == WAIT_W'(TIMEOUT - 1));
  assign captureEn  = (state == CAPTURE);
  assign converted  = sm_to_tc(mcp.temp_sign, mcp.temp_val);
  assign mcp.update = updateReg;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; a timeout takes priority over a late handshake edge.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (enable && timerDone) nextState = REQ;
      REQ:       nextState = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeoutHit)      nextState = IDLE;
        else if (!mcp.ready) nextState = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeoutHit)     nextState = IDLE;
        else if (mcp.ready) nextState = CAPTURE;
      end
      CAPTURE:   nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Period timer runs only while idle and enabled, so every poll starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state != IDLE || !enable || timerDone) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Timeout counter is zero during the request cycle and counts through both wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (nextState == REQ) begin
      waitCnt <= '0;
    end else if (state == REQ || inWait) begin
      waitCnt <= waitCnt + 1'b1;
    end else begin
      waitCnt <= '0;
    end
  end

  // Registered outputs: request pulse, captured sample and the sticky hang flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      updateReg    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      updateReg    <= (nextState == REQ);
      sample_valid <= captureEn;
      if (captureEn) sample <= converted;
      if (timeoutHit) timeout_err <= 1'b1;
    end
  end

  temp_minmax_alarm #(
    .HYST (HYST)
  ) uMinmaxAlarm (
    .clk         (clk),
    .rst         (rst),
    .captureEn   (captureEn),
    .clearMinmax (clear_minmax),
    .sampleIn    (converted),
    .alarmThresh (alarm_thresh),
    .tMin        (t_min),
    .tMax        (t_max),
    .alarm       (alarm)
  );

endmodule
